// File: rtl/cpu_ctrl_fsm.sv
// Multicycle fetch/decode/execute control FSM: parametrised memory latency and
// store hold, branch, HALT/resume, external stall and illegal-opcode flagging.
module cpu_ctrl_fsm #(
  parameter int MEM_LAT    = 1,
  parameter int STORE_HOLD = 1,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] instr_type,
  input  logic       cond_true,
  input  logic       stall,
  input  logic       resume,
  output logic       PC_enable,
  output logic       PC_load,
  output logic       IR_enable,
  output logic       R_enable,
  output logic       ALU_Bus_enable,
  output logic       reg_read,
  output logic       WrtBrm_en,
  output logic       Flags_Enable,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    STORE_WR  = 4'd3,
    LOAD_RD   = 4'd4,
    LOAD_WB   = 4'd5,
    STORE_HLD = 4'd6,
    JUMP      = 4'd7,
    BRANCH    = 4'd8,
    HALT      = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(MEM_LAT);
  localparam bit               HOLD_EN = (STORE_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_C  = HOLD_EN ? CNT_W'(STORE_HOLD - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_zero_s;

  logic pc_en_s, pc_ld_s, ir_en_s, r_en_s, alu_bus_s;
  logic rd_s, wr_s, flags_s, halted_s, illegal_s;

  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // State and shared wait counter; a stall freezes both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
      cnt_r   <= LAT_C;
    end else if (stall) begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
    end else begin
      case (state_r)
        FETCH: begin
          if (cnt_zero_s) begin
            state_r <= DECODE;
          end else begin
            cnt_r <= cnt_r - ONE_C;
          end
        end
        DECODE: begin
          cnt_r <= LAT_C;
          case (instr_type)
            3'b000:  state_r <= EXEC_R;
            3'b001:  state_r <= STORE_WR;
            3'b010:  state_r <= LOAD_RD;
            3'b011:  state_r <= JUMP;
            3'b100:  state_r <= BRANCH;
            3'b110:  state_r <= HALT;
            default: state_r <= FETCH;
          endcase
        end
        STORE_WR: begin
          if (HOLD_EN) begin
            state_r <= STORE_HLD;
            cnt_r   <= HOLD_C;
          end else begin
            state_r <= FETCH;
            cnt_r   <= LAT_C;
          end
        end
        STORE_HLD: begin
          if (cnt_zero_s) begin
            state_r <= FETCH;
            cnt_r   <= LAT_C;
          end else begin
            cnt_r <= cnt_r - ONE_C;
          end
        end
        LOAD_RD: begin
          if (cnt_zero_s) begin
            state_r <= LOAD_WB;
            cnt_r   <= LAT_C;
          end else begin
            cnt_r <= cnt_r - ONE_C;
          end
        end
        HALT: begin
          if (resume) begin
            state_r <= FETCH;
            cnt_r   <= LAT_C;
          end else begin
            state_r <= HALT;
          end
        end
        default: begin
          state_r <= FETCH;
          cnt_r   <= LAT_C;
        end
      endcase
    end
  end

  // Raw per-state controls; reset forces the idle pattern (bus mux on ALU).
  always_comb begin
    pc_en_s   = 1'b0;
    pc_ld_s   = 1'b0;
    ir_en_s   = 1'b0;
    r_en_s    = 1'b0;
    alu_bus_s = 1'b1;
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    flags_s   = 1'b0;
    halted_s  = 1'b0;
    illegal_s = 1'b0;
    if (reset) begin
      case (state_r)
        FETCH:  ir_en_s = cnt_zero_s;
        DECODE: begin
          pc_en_s   = 1'b1;
          illegal_s = (instr_type == 3'b111);
        end
        EXEC_R: begin
          r_en_s  = 1'b1;
          flags_s = 1'b1;
        end
        STORE_WR: begin
          alu_bus_s = 1'b0;
          rd_s      = 1'b1;
          wr_s      = 1'b1;
        end
        STORE_HLD: alu_bus_s = 1'b1;
        LOAD_RD: begin
          alu_bus_s = 1'b0;
          rd_s      = 1'b1;
        end
        LOAD_WB: begin
          alu_bus_s = 1'b0;
          r_en_s    = 1'b1;
        end
        JUMP: begin
          pc_ld_s = 1'b1;
          r_en_s  = 1'b1;
        end
        BRANCH: pc_ld_s  = cond_true;
        HALT:   halted_s = 1'b1;
        default: alu_bus_s = 1'b0;
      endcase
    end else begin
      alu_bus_s = 1'b1;
    end
  end

  // Stall suppresses every side-effecting strobe; bus select and read phase hold.
  assign PC_enable      = pc_en_s   & ~stall;
  assign PC_load        = pc_ld_s   & ~stall;
  assign IR_enable      = ir_en_s   & ~stall;
  assign R_enable       = r_en_s    & ~stall;
  assign WrtBrm_en      = wr_s      & ~stall;
  assign Flags_Enable   = flags_s   & ~stall;
  assign illegal        = illegal_s & ~stall;
  assign ALU_Bus_enable = alu_bus_s;
  assign reg_read       = rd_s;
  assign halted         = halted_s;
  assign state_o        = state_r;

endmodule
